fetch_unit: RTL
===============

# fetch_unit

Program-counter and instruction-fetch stage that serves the instruction decoder. It owns the PC register and drives both read addresses of the dual-port synchronous instruction memory. It returns the two fetched words (`pc`, `pc+1`) to the decoder with a valid flag, and applies the decoder's `cnt_en`, `pc_sload` and `new_pc` controls. It sits between the instruction memory and the decoder, and gives the decoder the fetch-side half of its interface.

## Interface
- `ADDR_W`, 16: PC and instruction-address width; instruction words are 16 bits.
- `RESET_PC`, 16'h0000: PC value after reset.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cnt_en`  in  1  from decoder: advance PC by 1.
- `pc_sload`  in  1  from decoder: load PC from `new_pc`.
- `new_pc`  in  ADDR_W  from decoder: jump target.
- `halt`  in  1  from decoder: current instruction is HALT.
- `instr_q1`, `instr_q2`  in  16 each  memory read data, ports 1/2.
- `instr_addr1`, `instr_addr2`  out  ADDR_W each  memory read addresses.
- `pc`  out  ADDR_W  address of `instruction1`.
- `instruction1`, `instruction2`  out  16 each  words at `pc` and `pc+1`.
- `instr_valid`  out  1  `instruction1/2` and `pc` are valid this cycle.
- `retired`  out  16  count of accepted instructions; wraps modulo 2^16.
- `halted`  out  1  block is in HALT state.

## Operation
- The instruction memory is synchronous-read. The address is registered at the edge and `q` is valid after that edge, so read latency is 1 cycle.
- State machine states are BOOT, RUN and HALT. Reset state is BOOT.
  - BOOT → RUN on the first edge after reset release.
  - RUN → HALT on an edge where `instr_valid && halt`.
  - HALT is left only by reset.
- Accept condition: `acc = (state==RUN) && instr_valid`. All decoder controls are ignored when `acc=0`.
- Combinational next PC:
  - `pc_sload` has priority: `npc = new_pc`.
  - otherwise, if `cnt_en`: `npc = pc+1`.
  - otherwise: `npc = pc`.
  - When `!acc` or `halt`: `npc = pc`.
  - All adds truncate to ADDR_W, so 16'hFFFF+1 = 16'h0000.
- Outputs `instr_addr1 = npc` and `instr_addr2 = npc+1` (wrapping). During reset both addresses are `RESET_PC` and `RESET_PC+1`.
- `pc` register loads `npc` each edge. Because the memory latches `npc` on the same edge, `instr_q1/2` always match `pc` from the following cycle on. Sequential flow and jumps therefore both run with no bubble.
- `instruction1/2 = instr_q1/2` when `instr_valid`, else 16'h0000.
- `instr_valid` register:
  - 0 in reset and in BOOT.
  - 1 in RUN.
  - cleared on entry to HALT.
- `retired` increments on every edge where `acc && (cnt_en || pc_sload)`, or `acc && halt` (the HALT instruction counts once).
- `halted = (state==HALT)`.
- The decoder's `cnt_en`/`pc_sload` may depend combinationally on `instruction1/2`. There is no combinational path from `instr_q` to `instr_addr` other than through the decoder, and memory registers break the loop.

## Timing
- Reset values:
  - `pc = RESET_PC`
  - `instr_valid = 0`
  - `instruction1/2 = 0`
  - `retired = 0`
  - `halted = 0`
  - state = BOOT
- Asserting reset mid-operation forces all of these values immediately, without waiting for a clock edge.
- First valid instruction: `instr_valid` rises 1 cycle after `rst_n` deasserts, with `instruction1 = mem[RESET_PC]`.
- Control latency: `cnt_en` or `pc_sload` sampled at edge N gives new `pc` and matching instruction words valid after edge N, i.e. in cycle N+1.
- Simultaneous `cnt_en` and `pc_sload`: the load wins, and `retired` increments by 1 only.
- `halt` with `cnt_en`/`pc_sload`: `halt` wins, and the PC is not changed.
- Hold (no control asserted): `pc` and addresses are stable, and the instruction words stay valid indefinitely.

## Test plan
- Reset release with `RESET_PC=0`, mem[0]=16'h1111, mem[1]=16'h2222 → `instr_valid=0` for the cycle after release, then `instr_valid=1`, `pc=0`, `instruction1=16'h1111`, `instruction2=16'h2222`.
- Hold `cnt_en=1` for 4 cycles → `pc` steps 0,1,2,3,4 with matching words every cycle, no bubble, `retired=4`.
- In one cycle, `pc_sload=1`, `new_pc=16'h0040`, `cnt_en=1` → next cycle `pc=16'h0040`, `instruction1=mem[0x40]`, `retired` +1 only.
- Load `pc=16'hFFFF` → `instr_addr2=16'h0000`; apply `cnt_en` → `pc=16'h0000`.
- Assert `halt` with `cnt_en=1` at `pc=5` → `halted=1`, `instr_valid=0`, `pc` stays 5, `retired` +1; further `cnt_en`/`pc_sload` have no effect until reset.
- Pull `rst_n` low between clock edges while running at `pc=16'h0040` → all outputs take reset values before the next edge; after release the BOOT sequence repeats from `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC register and dual-word instruction fetch feeding the decoder.
// Memory read latency of one cycle is hidden by addressing it with next-PC.
module fetch_unit #(
   parameter int                 ADDR_W   = 16,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cnt_en,
   input  logic              pc_sload,
   input  logic [ADDR_W-1:0] new_pc,
   input  logic              halt,
   input  logic [15:0]       instr_q1,
   input  logic [15:0]       instr_q2,
   output logic [ADDR_W-1:0] instr_addr1,
   output logic [ADDR_W-1:0] instr_addr2,
   output logic [ADDR_W-1:0] pc,
   output logic [15:0]       instruction1,
   output logic [15:0]       instruction2,
   output logic              instr_valid,
   output logic [15:0]       retired,
   output logic              halted
);
   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              valid_q, valid_d;
   logic [15:0]       retired_q, retired_d;
   logic              acc;
   always_comb begin
      acc       = (state_q == RUN) && valid_q;
      pc_d      = (!acc || halt) ? pc_q :
                  pc_sload       ? new_pc :
                  cnt_en         ? pc_q + ADDR_W'(1) : pc_q;
      state_d   = (state_q == BOOT)                     ? RUN :
                  (state_q == RUN && valid_q && halt)   ? HALT : state_q;
      valid_d   = (state_d == RUN);
      retired_d = retired_q + 16'(acc && (cnt_en || pc_sload || halt));
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= BOOT;
         pc_q      <= RESET_PC;
         valid_q   <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         valid_q   <= valid_d;
         retired_q <= retired_d;
      end
   end
   // Memory latches next-PC on the same edge pc_q does, so q always tracks pc.
   assign instr_addr1  = pc_d;
   assign instr_addr2  = pc_d + ADDR_W'(1);
   assign pc           = pc_q;
   assign instruction1 = valid_q ? instr_q1 : 16'h0000;
   assign instruction2 = valid_q ? instr_q2 : 16'h0000;
   assign instr_valid  = valid_q;
   assign retired      = retired_q;
   assign halted       = (state_q == HALT);
endmodule
